// File: rtl/vram_frame_writer_if.sv
// Pixel-stream handshake plus VRAM write-port signals of the frame writer.
// The writer itself uses the slave view; the pixel producer/VRAM side uses the master view.
interface vram_frame_writer_if;
  logic        pix_valid;
  logic        pix_ready;
  logic [5:0]  pix_data;
  logic        pix_sof;
  logic        vram_busy;
  logic [15:0] VramWAddr;
  logic [5:0]  VramWData;
  logic        VramWE;

  modport master (
    output pix_valid, pix_data, pix_sof, vram_busy,
    input  pix_ready, VramWAddr, VramWData, VramWE
  );

  modport slave (
    input  pix_valid, pix_data, pix_sof, vram_busy,
    output pix_ready, VramWAddr, VramWData, VramWE
  );
endinterface

// File: rtl/vram_frame_writer.sv
// Producer side of the 256x240 VRAM frame buffer: tracks raster position from
// start-of-frame, buffers pixels in a small FIFO and writes each to address {y,x}.
module vram_frame_writer #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                PCK,
  input  logic                RST,
  vram_frame_writer_if.slave  vif,
  output logic                frame_done,
  output logic                sync_err
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0]   DEPTH_C = FIFO_DEPTH[PTR_W:0];
  localparam logic [PTR_W:0]   CNT_ONE = 1;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;

  localparam logic [0:0] WAIT_SOF = 1'b0;
  localparam logic [0:0] ACTIVE   = 1'b1;

  logic [0:0]       state;
  logic [7:0]       x;
  logic [7:0]       y;

  logic [21:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [21:0]      head;

  logic fifo_full;
  logic fifo_empty;
  logic ready;
  logic accept;
  logic push;
  logic pop;
  logic [15:0] push_addr;

  assign fifo_full  = (count == DEPTH_C);
  assign fifo_empty = (count == '0);

  // Ready is forced low during reset so nothing is consumed while held in reset.
  assign ready  = !RST && !fifo_full;
  assign accept = vif.pix_valid && ready;
  assign push   = accept && ((state == ACTIVE) || vif.pix_sof);
  assign pop    = !fifo_empty && !vif.vram_busy;

  assign push_addr = vif.pix_sof ? '0 : {y, x};
  assign head      = mem[rd_ptr];

  assign vif.pix_ready = ready;
  assign vif.VramWE    = pop;
  assign vif.VramWAddr = fifo_empty ? '0 : head[21:6];
  assign vif.VramWData = fifo_empty ? '0 : head[5:0];

  always_ff @(posedge PCK) begin
    if (push) begin
      mem[wr_ptr] <= {push_addr, vif.pix_data};
    end
  end

  always_ff @(posedge PCK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // A sof always restarts the raster at (0,0); inside a frame it also flags a sync error.
  always_ff @(posedge PCK or posedge RST) begin
    if (RST) begin
      state      <= WAIT_SOF;
      x          <= '0;
      y          <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      if (accept) begin
        if (vif.pix_sof) begin
          sync_err <= (state == ACTIVE);
          state    <= ACTIVE;
          x        <= 8'd1;
          y        <= '0;
        end else if (state == ACTIVE) begin
          if (x == 8'd255) begin
            x <= '0;
            if (y == 8'd239) begin
              y          <= '0;
              state      <= WAIT_SOF;
              frame_done <= 1'b1;
            end else begin
              y <= y + 8'd1;
            end
          end else begin
            x <= x + 8'd1;
          end
        end
      end
    end
  end

endmodule
